// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared widths, defaults and entry types for the fetch queue.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    localparam int FETCH_D_S = 32;
    localparam int FQ_DEPTH  = 4;
    localparam int FQ_IDX_W  = 8;

    typedef logic [FETCH_D_S-1:0] fetch_word_t;

    typedef struct packed {
        logic [FQ_IDX_W-1:0] idx;
        fetch_word_t         pl;
    } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/fq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fq_ctrl
// Brief    : Pointers, occupancy, sequence-index counter and flush handling.
// Revision : 1.0
// ============================================================================
module fq_ctrl
    import fetch_pkg::*;
#(
    parameter  int DEPTH = FQ_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s1_vld,
    input  logic                s2_rdy,
    input  logic                flush,
    output logic                s1_rdy,
    output logic                s2_vld,
    output logic                push,
    output logic [AW-1:0]       wptr,
    output logic [AW-1:0]       rptr,
    output logic [FQ_IDX_W-1:0] idx,
    output logic [CW-1:0]       cnt
);

    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [FQ_IDX_W-1:0] r_idx;
    logic [CW-1:0]       r_cnt;
    logic                w_full;
    logic                w_push;
    logic                w_pop;

    // Ready is a function of registered count and flush only, so a pop at
    // full frees its slot for the following cycle, never the same one.
    assign w_full = (r_cnt == CW'(DEPTH));
    assign s1_rdy = ~w_full & ~flush;
    assign s2_vld = (r_cnt != '0);
    assign w_push = s1_vld & s1_rdy;
    assign w_pop  = s2_vld & s2_rdy & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
                r_idx  <= r_idx + FQ_IDX_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign push = w_push;
    assign wptr = r_wptr;
    assign rptr = r_rptr;
    assign idx  = r_idx;
    assign cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : In-order fetch word queue with sequence stamping and flush.
// Revision : 1.0
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int D_S   = FETCH_D_S,
    parameter  int DEPTH = FQ_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s1_vld,
    input  logic [D_S-1:0]      s1_pl,
    output logic                s1_rdy,
    output logic                s2_vld,
    output logic [D_S-1:0]      s2_pl,
    output logic [FQ_IDX_W-1:0] s2_idx,
    input  logic                s2_rdy,
    input  logic                flush,
    output logic [CW-1:0]       cnt
);

    // Same layout as fq_entry_t, but the payload follows this instance's D_S.
    typedef struct packed {
        logic [FQ_IDX_W-1:0] idx;
        logic [D_S-1:0]      pl;
    } entry_t;

    entry_t              r_mem [DEPTH];
    logic                w_push;
    logic [AW-1:0]       w_wptr;
    logic [AW-1:0]       w_rptr;
    logic [FQ_IDX_W-1:0] w_idx;

    fq_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .s1_vld (s1_vld),
        .s2_rdy (s2_rdy),
        .flush  (flush),
        .s1_rdy (s1_rdy),
        .s2_vld (s2_vld),
        .push   (w_push),
        .wptr   (w_wptr),
        .rptr   (w_rptr),
        .idx    (w_idx),
        .cnt    (cnt)
    );

    // Storage is deliberately unreset; the head is only meaningful with s2_vld.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wptr] <= '{idx: w_idx, pl: s1_pl};
        end
    end

    assign s2_pl  = r_mem[w_rptr].pl;
    assign s2_idx = r_mem[w_rptr].idx;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Randomized and directed bench for fetch_queue with queue model.
// Revision : 1.0
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        s1_vld;
    logic [31:0] s1_pl;
    logic        s1_rdy;
    logic        s2_vld;
    logic [31:0] s2_pl;
    logic [7:0]  s2_idx;
    logic        s2_rdy;
    logic        flush;
    logic [2:0]  cnt;

    fetch_queue #(
        .D_S   (32),
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s1_vld (s1_vld),
        .s1_pl  (s1_pl),
        .s1_rdy (s1_rdy),
        .s2_vld (s2_vld),
        .s2_pl  (s2_pl),
        .s2_idx (s2_idx),
        .s2_rdy (s2_rdy),
        .flush  (flush),
        .cnt    (cnt)
    );

    typedef struct {
        logic [7:0]  idx;
        logic [31:0] pl;
    } ment_t;

    ment_t mq[$];
    int    midx;
    int    n_pass;
    int    n_tot;
    bit    chk_on;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: an ordered list of (idx, payload) updated per sampled edge.
    initial begin
        midx = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                midx = 0;
            end else if (flush) begin
                mq.delete();
                midx = 0;
            end else begin
                bit do_push;
                bit do_pop;
                do_push = s1_vld && (mq.size() < DEPTH);
                do_pop  = s2_rdy && (mq.size() > 0);
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    ment_t e;
                    e.idx = midx[7:0];
                    e.pl  = s1_pl;
                    mq.push_back(e);
                    midx = (midx + 1) % 256;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus head stability under stall.
    initial begin
        bit          held;
        logic [31:0] held_pl;
        logic [7:0]  held_idx;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !chk_on) begin
                held = 1'b0;
            end else begin
                chk("cnt", 64'(cnt), 64'(mq.size()));
                chk("s1_rdy", 64'(s1_rdy), 64'((mq.size() != DEPTH) && !flush));
                chk("s2_vld", 64'(s2_vld), 64'(mq.size() != 0));
                if (mq.size() != 0) begin
                    chk("s2_pl", 64'(s2_pl), 64'(mq[0].pl));
                    chk("s2_idx", 64'(s2_idx), 64'(mq[0].idx));
                end
                if (held) begin
                    chk("stall_pl", 64'(s2_pl), 64'(held_pl));
                    chk("stall_idx", 64'(s2_idx), 64'(held_idx));
                end
                held     = s2_vld && !s2_rdy && !flush;
                held_pl  = s2_pl;
                held_idx = s2_idx;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_tot  = 0;
        chk_on = 1'b0;
        rst_n  = 1'b0;
        s1_vld = 1'b0;
        s1_pl  = '0;
        s2_rdy = 1'b0;
        flush  = 1'b0;
        repeat (3) step();
        rst_n  = 1'b1;
        chk_on = 1'b1;
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_s1_rdy", 64'(s1_rdy), 64'd1);
        chk("rst_s2_vld", 64'(s2_vld), 64'd0);

        // Fill to full with decode stalled.
        for (int i = 0; i < 4; i++) begin
            s1_vld = 1'b1;
            s1_pl  = 32'h4000_0000 + 32'(i);
            step();
        end
        s1_vld = 1'b0;
        chk("full_cnt", 64'(cnt), 64'd4);
        chk("full_s1_rdy", 64'(s1_rdy), 64'd0);
        chk("full_head_pl", 64'(s2_pl), 64'h4000_0000);
        chk("full_head_idx", 64'(s2_idx), 64'd0);

        // Pop at full with a push offered: the push is not taken that cycle.
        s1_vld = 1'b1;
        s1_pl  = 32'h4000_0004;
        s2_rdy = 1'b1;
        step();
        s2_rdy = 1'b0;
        chk("popfull_cnt", 64'(cnt), 64'd3);
        chk("popfull_s1_rdy", 64'(s1_rdy), 64'd1);
        chk("popfull_head", 64'(s2_pl), 64'h4000_0001);
        step();
        s1_vld = 1'b0;
        chk("refill_cnt", 64'(cnt), 64'd4);

        // Down to 3 entries, then flush with push and pop both offered.
        s2_rdy = 1'b1;
        step();
        s2_rdy = 1'b0;
        chk("pre_flush_cnt", 64'(cnt), 64'd3);
        flush  = 1'b1;
        s1_vld = 1'b1;
        s2_rdy = 1'b1;
        #1;
        chk("flush_s1_rdy", 64'(s1_rdy), 64'd0);
        step();
        flush  = 1'b0;
        s1_vld = 1'b0;
        s2_rdy = 1'b0;
        chk("post_flush_cnt", 64'(cnt), 64'd0);
        chk("post_flush_vld", 64'(s2_vld), 64'd0);
        s1_vld = 1'b1;
        s1_pl  = 32'h0000_5555;
        step();
        s1_vld = 1'b0;
        chk("post_flush_idx", 64'(s2_idx), 64'd0);
        chk("post_flush_pl", 64'(s2_pl), 64'h0000_5555);

        // Held flush keeps the queue empty and closed.
        flush  = 1'b1;
        s1_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hflush_cnt", 64'(cnt), 64'd0);
            chk("hflush_s1_rdy", 64'(s1_rdy), 64'd0);
        end
        flush  = 1'b0;

        // Streaming: one word per cycle, idx wraps past 255.
        s2_rdy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            s1_pl = 32'h1000 + 32'(k);
            step();
            chk("stream_cnt", 64'(cnt), 64'd1);
            chk("stream_pl", 64'(s2_pl), 64'(32'h1000 + 32'(k)));
            if (k == 255) chk("stream_idx255", 64'(s2_idx), 64'd255);
            if (k == 256) chk("stream_idx_wrap", 64'(s2_idx), 64'd0);
        end
        s1_vld = 1'b0;
        step();
        chk("stream_drain", 64'(cnt), 64'd0);

        // Randomized traffic with occasional flushes.
        for (int c = 0; c < 10000; c++) begin
            s1_vld = 1'($urandom_range(0, 1));
            s2_rdy = 1'($urandom_range(0, 1));
            flush  = ($urandom_range(0, 99) == 0);
            s1_pl  = $urandom;
            step();
        end
        s1_vld = 1'b0;
        s2_rdy = 1'b0;
        flush  = 1'b1;
        step();
        flush  = 1'b0;

        // Asynchronous reset mid-cycle with two words queued.
        s1_vld = 1'b1;
        s1_pl  = 32'hAAAA_0001;
        step();
        s1_pl  = 32'hAAAA_0002;
        step();
        s1_vld = 1'b0;
        chk("arst_pre_cnt", 64'(cnt), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", 64'(cnt), 64'd0);
        chk("arst_s2_vld", 64'(s2_vld), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_after_cnt", 64'(cnt), 64'd0);
        chk("arst_after_s1_rdy", 64'(s1_rdy), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter D_S, default 32, payload width in bits.
REQ-002 Parameter DEPTH, default 4, number of queue entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion is synchronous to clk.
REQ-005 s1_vld  input  1  upstream fetched-word valid.
REQ-006 s1_pl  input  D_S  upstream fetched word.
REQ-007 s1_rdy  output  1  queue can accept a word this cycle.
REQ-008 s2_vld  output  1  head word valid toward decode.
REQ-009 s2_pl  output  D_S  head word.
REQ-010 s2_idx  output  8  sequence index of the head word.
REQ-011 s2_rdy  input  1  decode accepts the head word.
REQ-012 flush  input  1  discard all queued words (branch redirect).
REQ-013 cnt  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 Push when s1_vld & s1_rdy; pop when s2_vld & s2_rdy; both are sampled on the same rising edge.
REQ-015 s1_rdy = (cnt != DEPTH) & ~flush; it has no combinational dependence on s2_rdy or s1_vld.
REQ-016 s2_vld = (cnt != 0); s2_pl and s2_idx come from the head entry; no combinational path from s1_* to s2_*.
REQ-017 Latency: a word pushed at edge N is presented on s2_pl after edge N when the queue was empty.
REQ-018 s2_pl and s2_idx stay stable while s2_vld & ~s2_rdy.
REQ-019 Words leave in push order.
REQ-020 Simultaneous push and pop leaves cnt unchanged; both pointers advance.
REQ-021 At full, s1_rdy is low; a pop at full frees a slot that is usable from the next cycle, not the same cycle.
REQ-022 At empty, s2_rdy is ignored and no pointer or count change occurs.
REQ-023 Read and write pointers wrap modulo DEPTH.
REQ-024 The idx counter is 8 bits and is stamped into each entry on push. It increments by 1 per push and wraps from 255 to 0.
REQ-025 While flush is high at an edge:
- cnt, the read pointer, the write pointer and the idx counter clear to 0;
- any push or pop in that cycle has no effect;
- s2_vld is 0 from the next cycle.
REQ-026 flush held for multiple cycles keeps the queue empty with s1_rdy low.

Reset
REQ-027 On rst_n low: cnt=0, pointers=0, idx counter=0, s2_vld=0, s1_rdy=1 (once rst_n is high and flush is low).
REQ-028 Entry storage is not reset; s2_pl is don't-care while s2_vld=0.
REQ-029 Reset asserted mid-operation discards all contents immediately, with no partial pop.

Structure
REQ-030 Package fetch_pkg holds:
- FETCH_D_S (32);
- FQ_DEPTH (4);
- the typedef fetch_word_t (D_S bits);
- the typedef fq_entry_t (struct {idx[7:0], pl}).
REQ-031 One sub-module, fq_ctrl, holds the pointers, count, idx counter and flush logic; the storage array stays in fetch_queue.

Verification
REQ-032 Reset then push 0x4000_0000..0x4000_0003 with s2_rdy=0 -> cnt=4, s1_rdy=0, s2_pl=0x4000_0000, s2_idx=0.
REQ-033 From full, s2_rdy=1 for one cycle while s1_vld=1 -> pop 0x4000_0000; s1_rdy=1 next cycle; cnt=3 then 4 after the following push.
REQ-034 Continuous s1_vld=1 and s2_rdy=1 for 300 words -> cnt remains 1, one word per cycle, s2_idx wraps 255->0, payloads in order.
REQ-035 Queue holding 3 words, flush=1 with s1_vld=1 and s2_rdy=1 -> no pop is counted, cnt=0 and s2_vld=0 next cycle; the next push gets idx 0.
REQ-036 Random s1_vld and s2_rdy at 50% for 10k cycles against a scoreboard -> no loss, duplication or reorder; s2_pl is stable under stall.
REQ-037 rst_n pulsed low asynchronously mid-cycle with cnt=2 -> s2_vld=0 and cnt=0 without waiting for a clock edge.
